// File: rtl/i2s_tx_if.sv
// Sample-side and I2S-side signals of the I2S transmitter.
// master = upstream/stimulus side, slave = i2s_tx_unit.
interface i2s_tx_if #(
  parameter int SAMPLE_W = 24
);
  logic                play_in;
  logic                tick_in;
  logic [SAMPLE_W-1:0] audio0_in;
  logic [SAMPLE_W-1:0] audio1_in;
  logic                clr_in;
  logic                req_out;
  logic                sck_out;
  logic                ws_out;
  logic                sdo_out;
  logic                busy_out;
  logic                underrun_out;

  modport master (
    output play_in, tick_in, audio0_in, audio1_in, clr_in,
    input  req_out, sck_out, ws_out, sdo_out, busy_out, underrun_out
  );

  modport slave (
    input  play_in, tick_in, audio0_in, audio1_in, clr_in,
    output req_out, sck_out, ws_out, sdo_out, busy_out, underrun_out
  );
endinterface

// File: rtl/i2s_tx_unit.sv
// I2S Philips-format transmitter: one-entry stereo holding register feeding a
// 64-slot frame shifter, with graceful stop and sticky underrun reporting.
module i2s_tx_unit #(
  parameter int SCK_DIV  = 4,
  parameter int SAMPLE_W = 24
) (
  input  logic    clk,
  input  logic    rst,
  i2s_tx_if.slave bus
);
  localparam int          PAD_W    = 32 - SAMPLE_W;
  localparam logic [8:0]  DIV_LAST = 9'(2 * SCK_DIV - 1);
  localparam logic [8:0]  DIV_HALF = 9'(SCK_DIV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STOP
  } state_t;

  state_t              state, state_nxt;
  logic [8:0]          div_cnt;
  logic [5:0]          slot_cnt;
  logic [63:0]         frame;
  logic [SAMPLE_W-1:0] hold_l, hold_r;
  logic                hold_vld;
  logic                load;
  logic                slot_end, frame_end;
  logic                ur_set;
  logic                req_q, underrun_q;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign frame_end = slot_end && (slot_cnt == 6'd63);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A frame boundary in STOP (or RUN with play dropped) ends in IDLE without a
  // load; re-raised play at the boundary keeps the stream going seamlessly.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.play_in) begin
          state_nxt = ST_RUN;
          load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (frame_end) begin
          if (bus.play_in) load = 1'b1;
          else             state_nxt = ST_IDLE;
        end else if (!bus.play_in) begin
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (frame_end) begin
          if (bus.play_in) begin
            state_nxt = ST_RUN;
            load      = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else if (bus.play_in) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The load leaving IDLE is the priming frame and never counts as underrun.
  assign ur_set = load && !hold_vld && (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (load || state_nxt == ST_IDLE) begin
      div_cnt  <= '0;
      slot_cnt <= '0;
    end else if (slot_end) begin
      div_cnt  <= '0;
      slot_cnt <= slot_cnt + 6'd1;
    end else begin
      div_cnt  <= div_cnt + 9'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame <= '0;
    end else if (load) begin
      if (hold_vld) frame <= {hold_l, {PAD_W{1'b0}}, hold_r, {PAD_W{1'b0}}};
      else          frame <= '0;
    end else if (state_nxt == ST_IDLE) begin
      frame <= '0;
    end else if (slot_end) begin
      frame <= {frame[62:0], 1'b0};
    end
  end

  // A tick on the load edge wins: the frame got the old contents above.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l   <= '0;
      hold_r   <= '0;
      hold_vld <= 1'b0;
    end else if (bus.tick_in) begin
      hold_l   <= bus.audio0_in;
      hold_r   <= bus.audio1_in;
      hold_vld <= 1'b1;
    end else if (load) begin
      hold_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      req_q <= load;
      if (ur_set)          underrun_q <= 1'b1;
      else if (bus.clr_in) underrun_q <= 1'b0;
    end
  end

  // WS leads the data by one slot: high over slots 31..62.
  assign bus.busy_out     = (state != ST_IDLE);
  assign bus.req_out      = req_q;
  assign bus.underrun_out = underrun_q;
  assign bus.sck_out      = bus.busy_out && (div_cnt >= DIV_HALF);
  assign bus.ws_out       = bus.busy_out && (slot_cnt >= 6'd31) && (slot_cnt <= 6'd62);
  assign bus.sdo_out      = bus.busy_out && frame[63];
endmodule

// File: tb/tb_i2s_tx_unit.sv
// Directed bench for i2s_tx_unit with a frame scoreboard and reference model.
module tb_i2s_tx_unit;
  localparam int D  = 2;
  localparam int FR = 128 * D;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_tx_if #(.SAMPLE_W(24)) bus();

  i2s_tx_unit #(.SCK_DIV(D), .SAMPLE_W(24)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] q[$];
  logic [23:0] hl = '0, hr = '0;
  logic        hv = 1'b0, eu = 1'b0;
  int          tick_k, drop_k, raise_k, clr_k, rst_k;
  logic [23:0] tl, tr;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic no_hooks();
    tick_k = -1; drop_k = -1; raise_k = -1; clr_k = -1; rst_k = -1;
  endtask

  // Model of the clock edge about to happen, using the inputs now driven.
  task automatic model_edge(input logic load, input logic prime);
    logic set;
    set = load && !hv && !prime;
    if (load) q.push_back(hv ? {hl, 8'h00, hr, 8'h00} : 64'h0);
    if (set)             eu = 1'b1;
    else if (bus.clr_in) eu = 1'b0;
    if (bus.tick_in) begin
      hl = bus.audio0_in; hr = bus.audio1_in; hv = 1'b1;
    end else if (load) begin
      hv = 1'b0;
    end
  endtask

  task automatic idle_step();
    chk("idle_busy", bus.busy_out, 1'b0);
    chk("idle_req", bus.req_out, 1'b0);
    chk("idle_sck", bus.sck_out, 1'b0);
    chk("idle_ws", bus.ws_out, 1'b0);
    chk("idle_sdo", bus.sdo_out, 1'b0);
    chk("idle_underrun", bus.underrun_out, eu);
    model_edge(bus.play_in, 1'b1);
    @(posedge clk); #1;
    bus.tick_in = 1'b0; bus.clr_in = 1'b0;
  endtask

  // Checks one whole frame cycle by cycle, starting at its first cycle.
  task automatic run_frame();
    logic [63:0] fr;
    int s, ph;
    fr = '0;
    checks++;
    assert (q.size() > 0) else begin
      errors++;
      $error("FAIL frame_queue: observed=empty expected=pending frame");
    end
    if (q.size() > 0) fr = q.pop_front();
    for (int k = 0; k < FR; k++) begin
      s  = k / (2 * D);
      ph = k % (2 * D);
      chk("sck", bus.sck_out, ph >= D);
      chk("ws", bus.ws_out, (s >= 31) && (s <= 62));
      chk("sdo", bus.sdo_out, fr[63-s]);
      chk("req", bus.req_out, k == 0);
      chk("busy", bus.busy_out, 1'b1);
      chk("underrun", bus.underrun_out, eu);
      if (k == drop_k)  bus.play_in = 1'b0;
      if (k == raise_k) bus.play_in = 1'b1;
      if (k == clr_k)   bus.clr_in  = 1'b1;
      if (k == tick_k) begin
        bus.tick_in = 1'b1; bus.audio0_in = tl; bus.audio1_in = tr;
      end
      if (k == rst_k) begin
        rst = 1'b1; hv = 1'b0; eu = 1'b0; q.delete();
        @(posedge clk); #1;
        rst = 1'b0; bus.tick_in = 1'b0; bus.clr_in = 1'b0;
        return;
      end
      model_edge((k == FR - 1) && bus.play_in, 1'b0);
      @(posedge clk); #1;
      bus.tick_in = 1'b0; bus.clr_in = 1'b0;
    end
  endtask

  initial begin
    bus.play_in = 1'b0; bus.tick_in = 1'b0; bus.clr_in = 1'b0;
    bus.audio0_in = '0; bus.audio1_in = '0;
    tl = '0; tr = '0;
    no_hooks();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle_step();
    idle_step();

    // priming frame, tick lands mid-frame for the next one
    bus.play_in = 1'b1;
    idle_step();
    no_hooks(); tick_k = 100; tl = 24'hA5F00F; tr = 24'h800001;
    run_frame();
    // data frame; the following load finds no sample
    no_hooks();
    run_frame();
    // zero frame with underrun, cleared, then tick on the load edge
    no_hooks(); clr_k = 10; tick_k = FR - 1; tl = 24'h123456; tr = 24'hFEDCBA;
    run_frame();
    no_hooks();
    run_frame();
    // ticked sample frame; stop requested mid slot 10
    no_hooks(); drop_k = 10 * 2 * D + 1;
    run_frame();
    repeat (3) idle_step();
    bus.clr_in = 1'b1;
    idle_step();
    idle_step();

    // capture while idle, then restart with stop/restart inside the frame
    bus.tick_in = 1'b1; bus.audio0_in = 24'h7FFFFF; bus.audio1_in = 24'h000100;
    idle_step();
    bus.play_in = 1'b1;
    idle_step();
    no_hooks(); drop_k = 50; raise_k = 40 * 2 * D + 1;
    run_frame();
    // reset during slot 20 with play held high
    no_hooks(); rst_k = 20 * 2 * D + 1;
    run_frame();
    idle_step();
    no_hooks(); drop_k = 100;
    run_frame();
    idle_step();
    idle_step();

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL queue_drain: observed=%0d expected=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
